// File: rtl/qspi_flash_read_ctrl.sv
// qspi_flash_read_ctrl: AXI4-Lite read-only slave fetching 32-bit words from QSPI flash via Fast Read Quad I/O (EBh)
module qspi_flash_read_ctrl #(
    parameter int          FLASH_ADDR_W = 24,
    parameter int          HALF_DIV     = 2,
    parameter int          CS_HIGH_CYC  = 4,
    parameter logic [7:0]  MODE_BYTE    = 8'h00
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        CS_n,
    output logic        SCLK,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
);
    localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
    localparam int GW = $clog2(CS_HIGH_CYC + 1);
    localparam int ANIB = FLASH_ADDR_W / 4;
    localparam logic [7:0] CMD_EB = 8'hEB;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, RESP, CS_GAP} state_t;

    state_t                  state, state_nxt;
    logic [DW-1:0]           div_cnt;
    logic [2:0]              cnt;
    logic [GW-1:0]           gap_cnt;
    logic                    sclk_q;
    logic                    cs_n_q;
    logic [FLASH_ADDR_W-1:0] addr_q;
    logic [31:0]             rdata_q;
    logic                    active, active_nxt, tick, sclk_rise, sclk_fall, last, gap_ok;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^araddr[31:FLASH_ADDR_W];
    assign active     = state inside {CMD, ADDR, MODE, DUMMY, DATA};
    assign active_nxt = state_nxt inside {CMD, ADDR, MODE, DUMMY, DATA};
    assign tick       = active && div_cnt == DW'(HALF_DIV - 1);
    assign sclk_rise  = tick && !sclk_q;
    assign sclk_fall  = tick && sclk_q;
    assign gap_ok     = gap_cnt >= GW'(CS_HIGH_CYC - 1);
    assign last       = (state == CMD)   ? cnt == 3'd7 :
                        (state == ADDR)  ? cnt == 3'(ANIB - 1) :
                        (state == MODE)  ? cnt == 3'd1 :
                        (state == DUMMY) ? cnt == 3'd3 : cnt == 3'd7;

    // State register; reset parks in CS_GAP so CS_n stays high for the minimum gap
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= CS_GAP;
        else        state <= state_nxt;
    end

    // Next state: phases advance on the SCLK falling edge that ends their last cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arvalid ? CMD : IDLE;
            CMD:     state_nxt = (sclk_fall && last) ? ADDR : CMD;
            ADDR:    state_nxt = (sclk_fall && last) ? MODE : ADDR;
            MODE:    state_nxt = (sclk_fall && last) ? DUMMY : MODE;
            DUMMY:   state_nxt = (sclk_fall && last) ? DATA : DUMMY;
            DATA:    state_nxt = (sclk_fall && last) ? RESP : DATA;
            RESP:    state_nxt = rready ? (gap_ok ? IDLE : CS_GAP) : RESP;
            CS_GAP:  state_nxt = gap_ok ? IDLE : CS_GAP;
            default: state_nxt = CS_GAP;
        endcase
    end

    // Datapath: SCLK divider, phase counter, address shifter, data capture, CS gap timer
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            cnt     <= '0;
            gap_cnt <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            div_cnt <= (!active || tick) ? '0 : div_cnt + 1'b1;
            sclk_q  <= active && (tick ? !sclk_q : sclk_q);
            cs_n_q  <= !active_nxt;
            cnt     <= !active ? '0 : sclk_fall ? (last ? '0 : cnt + 3'd1) : cnt;
            gap_cnt <= active ? '0 : (gap_cnt == GW'(CS_HIGH_CYC)) ? gap_cnt : gap_cnt + 1'b1;
            if (state == IDLE && arvalid)
                addr_q <= araddr[FLASH_ADDR_W-1:0];
            else if (state == ADDR && sclk_fall)
                addr_q <= addr_q << 4;
            if (state == DATA && sclk_rise)
                rdata_q <= {rdata_q[27:0], io_in};
        end
    end

    // Outputs decoded from state; pad-facing CS_n and SCLK come straight from flops
    always_comb begin
        arready = state == IDLE;
        rvalid  = state == RESP;
        rresp   = 2'b00;
        rdata   = rdata_q;
        CS_n    = cs_n_q;
        SCLK    = sclk_q;
        io_oe   = (state == CMD) ? 4'b0001 : (state == ADDR || state == MODE) ? 4'hF : 4'h0;
        io_out  = (state == CMD)  ? {3'b000, CMD_EB[3'd7 - cnt]} :
                  (state == ADDR) ? addr_q[FLASH_ADDR_W-1 -: 4] :
                  (state == MODE) ? (cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4]) : 4'h0;
    end
endmodule

// File: tb/tb_qspi_flash_read_ctrl.sv
// tb_qspi_flash_read_ctrl: scoreboard bench with a behavioural QSPI flash, HALF_DIV=2 and HALF_DIV=1 instances
module tb_qspi_flash_read_ctrl;
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [1:0][31:0] araddr = '0;
    logic [1:0][31:0] rdata;
    logic [1:0][1:0]  rresp;
    logic [1:0]       arvalid = '0, rready = 2'b11;
    logic [1:0]       arready, rvalid, cs_n, sclk;
    logic [1:0][3:0]  io_out, io_oe;
    logic [1:0][3:0]  io_in = '0;

    always #5 ACLK = ~ACLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        qspi_flash_read_ctrl #(.HALF_DIV(g == 0 ? 2 : 1)) u_dut (
            .ACLK(ACLK), .ARESET(ARESET),
            .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
            .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
            .CS_n(cs_n[g]), .SCLK(sclk[g]), .io_out(io_out[g]), .io_oe(io_oe[g]), .io_in(io_in[g])
        );
    end

    typedef struct packed {
        logic        inst;
        logic [31:0] data;
        logic [23:0] addr;
        logic [15:0] lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   to_cnt = 0, to_seen = 0;
    bit   done = 0, done_chk = 0;

    int               cyc = 0;
    int               hs[2], lat_meas[2], gap[2], edge_n[2];
    logic [1:0]       prv_rvalid = '0, prv_rready = '0, prv_cs = 2'b11, prv_sclk = '0;
    logic [1:0][7:0]  cap_cmd = '0, cap_mode = '0;
    logic [1:0][23:0] cap_addr = '0;
    logic [1:0][31:0] word = '0;

    // flash contents
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        case (a)
            24'h000010: return 32'hDEADBEEF;
            24'h123456: return 32'hCAFEF00D;
            24'h000020: return 32'hA5A50F0F;
            24'h000100: return 32'h0BADC0DE;
            24'h000104: return 32'h76543210;
            default:    return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor and flash model, sampled on the falling ACLK edge
    always @(negedge ACLK) begin
        exp_t e;
        logic [31:0] sh;
        int k;
        cyc++;
        if (to_cnt != to_seen) begin
            tests += to_cnt - to_seen;
            fails += to_cnt - to_seen;
            to_seen = to_cnt;
        end
        for (int g = 0; g < 2; g++) begin
            if (ARESET) begin
                chk("rst_cs_n", 32'(cs_n[g]), 32'd1);
                chk("rst_sclk", 32'(sclk[g]), 32'd0);
                chk("rst_io_oe", 32'(io_oe[g]), 32'd0);
                chk("rst_rvalid", 32'(rvalid[g]), 32'd0);
                chk("rst_arready", 32'(arready[g]), 32'd0);
                chk("rst_rdata", rdata[g], 32'd0);
            end else begin
                if (arready[g]) begin
                    chk("arready_only_idle", 32'({cs_n[g], rvalid[g]}), 32'b10);
                    if (arvalid[g]) hs[g] = cyc;
                end
                if (cs_n[g]) chk("sclk_idle_low", 32'(sclk[g]), 32'd0);
                if (prv_rvalid[g] && !prv_rready[g]) chk("rvalid_hold", 32'(rvalid[g]), 32'd1);
                if (rvalid[g] && sb.size() > 0) chk("rdata_stable", rdata[g], sb[0].data);
                if (rvalid[g] && !prv_rvalid[g]) lat_meas[g] = cyc - hs[g];
                if (rvalid[g] && rready[g]) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rvalid: inst %0d got rdata %h, expected no response", g, rdata[g]);
                    end else begin
                        e = sb.pop_front();
                        chk("inst", 32'(g), 32'(e.inst));
                        chk("rdata", rdata[g], e.data);
                        chk("rresp", 32'(rresp[g]), 32'd0);
                        chk("wire_cmd", 32'(cap_cmd[g]), 32'hEB);
                        chk("wire_addr", 32'(cap_addr[g]), 32'(e.addr));
                        chk("wire_mode", 32'(cap_mode[g]), 32'h00);
                        if (e.lat != 0) chk("latency", 32'(lat_meas[g]), 32'(e.lat));
                    end
                end
            end
            if (!cs_n[g] && prv_cs[g]) begin
                chk("cs_gap_min", 32'(gap[g] >= 4), 32'd1);
                edge_n[g] = 0;
            end
            gap[g] = cs_n[g] ? gap[g] + 1 : 0;
            if (!cs_n[g] && sclk[g] && !prv_sclk[g]) begin
                chk("io_oe_phase", 32'(io_oe[g]), edge_n[g] < 8 ? 32'h1 : edge_n[g] < 16 ? 32'hF : 32'h0);
                if (edge_n[g] < 8)       cap_cmd[g]  = {cap_cmd[g][6:0], io_out[g][0]};
                else if (edge_n[g] < 14) cap_addr[g] = {cap_addr[g][19:0], io_out[g]};
                else if (edge_n[g] < 16) cap_mode[g] = {cap_mode[g][3:0], io_out[g]};
                if (edge_n[g] == 13) word[g] = flash_word(cap_addr[g]);
                edge_n[g]++;
            end
            if (!cs_n[g] && !sclk[g] && prv_sclk[g]) begin
                k = edge_n[g] - 1;
                if (k >= 19 && k <= 26) begin
                    sh = word[g] >> (28 - 4 * (k - 19));
                    io_in[g] = sh[3:0];
                end
            end
            prv_rvalid[g] = rvalid[g];
            prv_rready[g] = rready[g];
            prv_cs[g]     = cs_n[g];
            prv_sclk[g]   = sclk[g];
        end
        if (done && !done_chk) begin
            done_chk = 1;
            chk("sb_empty", 32'(sb.size()), 32'd0);
        end
    end

    task automatic hs_wait(input int g);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge ACLK);
            ok = arready[g] && arvalid[g];
        end
        if (!ok) begin
            $display("FAIL handshake_timeout: inst %0d arready never seen, expected within 400 cycles", g);
            to_cnt++;
        end
        @(posedge ACLK) #1;
    endtask

    task automatic wait_empty();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge ACLK);
            ok = sb.size() == 0;
        end
        if (!ok) begin
            $display("FAIL response_timeout: %0d responses pending, expected 0 within 2000 cycles", sb.size());
            to_cnt++;
            sb.delete();
        end
        @(posedge ACLK) #1;
    endtask

    task automatic rd(input int g, input logic [31:0] a, input logic [31:0] d, input logic [23:0] fa, input int lat);
        sb.push_back({g[0], d, fa, 16'(lat)});
        arvalid[g] = 1'b1;
        araddr[g]  = a;
        hs_wait(g);
        arvalid[g] = 1'b0;
        araddr[g]  = 32'hBAD0BAD0;
    endtask

    initial begin
        bit ok;
        repeat (5) @(posedge ACLK);
        #1 ARESET = 1'b0;
        rd(0, 32'h0000_0010, 32'hDEADBEEF, 24'h000010, 113);
        wait_empty();
        rd(0, 32'hFF12_3456, 32'hCAFEF00D, 24'h123456, 113);
        wait_empty();
        sb.push_back({1'b0, 32'h0BADC0DE, 24'h000100, 16'd113});
        sb.push_back({1'b0, 32'h76543210, 24'h000104, 16'd113});
        arvalid[0] = 1'b1;
        araddr[0]  = 32'h100;
        hs_wait(0);
        araddr[0]  = 32'h104;
        hs_wait(0);
        arvalid[0] = 1'b0;
        wait_empty();
        rready[0] = 1'b0;
        rd(0, 32'h10, 32'hDEADBEEF, 24'h000010, 113);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge ACLK);
            ok = rvalid[0];
        end
        if (!ok) begin
            $display("FAIL stall_rvalid_timeout: rvalid low, expected high within 400 cycles");
            to_cnt++;
        end
        repeat (20) @(posedge ACLK);
        #1 rready[0] = 1'b1;
        wait_empty();
        arvalid[0] = 1'b1;
        araddr[0]  = 32'h10;
        hs_wait(0);
        arvalid[0] = 1'b0;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge ACLK);
            ok = edge_n[0] >= 9;
        end
        if (!ok) begin
            $display("FAIL addr_phase_timeout: edge %0d, expected >= 9 within 400 cycles", edge_n[0]);
            to_cnt++;
        end
        @(posedge ACLK) #2 ARESET = 1'b1;
        @(posedge ACLK) #1 ARESET = 1'b0;
        rd(0, 32'h10, 32'hDEADBEEF, 24'h000010, 113);
        wait_empty();
        rd(1, 32'h20, 32'hA5A50F0F, 24'h000020, 57);
        wait_empty();
        rd(1, 32'h10, 32'hDEADBEEF, 24'h000010, 57);
        wait_empty();
        done = 1;
        repeat (3) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
